// File: rtl/sum_seq_pkg.sv
// Shared encodings for the sum sequencer: state codes, mux selects, ALU op.
package sum_seq_pkg;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_TEST = 3'd2;
    localparam logic [2:0] ST_ADD  = 3'd3;
    localparam logic [2:0] ST_DEC  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam logic N_SEL_EXT = 1'b1;
    localparam logic N_SEL_ALU = 1'b0;
    localparam logic A_SEL_SUM = 1'b1;
    localparam logic A_SEL_N   = 1'b0;
    localparam logic B_SEL_N   = 1'b1;
    localparam logic B_SEL_ONE = 1'b0;
    localparam logic ALU_ADD   = 1'b0;
    localparam logic ALU_SUB   = 1'b1;
endpackage

// File: rtl/sum_seq_decode.sv
// Pure state-to-control decode; illegal codes decode to the all-zero IDLE vector.
module sum_seq_decode
    import sum_seq_pkg::*;
(
    input  logic [2:0] state,
    output logic       ld_n,
    output logic       ld_sum,
    output logic       clr_sum,
    output logic       n_sel,
    output logic       a_sel,
    output logic       b_sel,
    output logic       alu_sub,
    output logic       busy,
    output logic       done
);
    always_comb begin
        ld_n    = 1'b0;
        ld_sum  = 1'b0;
        clr_sum = 1'b0;
        n_sel   = 1'b0;
        a_sel   = 1'b0;
        b_sel   = 1'b0;
        alu_sub = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_LOAD: begin
                ld_n    = 1'b1;
                n_sel   = N_SEL_EXT;
                clr_sum = 1'b1;
                busy    = 1'b1;
            end
            ST_TEST: busy = 1'b1;
            ST_ADD: begin
                ld_sum  = 1'b1;
                a_sel   = A_SEL_SUM;
                b_sel   = B_SEL_N;
                alu_sub = ALU_ADD;
                busy    = 1'b1;
            end
            ST_DEC: begin
                ld_n    = 1'b1;
                n_sel   = N_SEL_ALU;
                a_sel   = A_SEL_N;
                b_sel   = B_SEL_ONE;
                alu_sub = ALU_SUB;
                busy    = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/sum_seq_ctrl.sv
// Sequencer for the dedicated sum datapath: SUM = N + (N-1) + ... + 1 (mod 256).
// Controls are decoded from the next state and registered alongside it, so every output is a flop.
module sum_seq_ctrl
    import sum_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ack,
    input  logic       n_zero,
    output logic       ld_n,
    output logic       ld_sum,
    output logic       clr_sum,
    output logic       n_sel,
    output logic       a_sel,
    output logic       b_sel,
    output logic       alu_sub,
    output logic       busy,
    output logic       done,
    output logic [7:0] iter_count,
    output logic [2:0] state
);
    logic [2:0] state_r;
    logic [2:0] state_nxt;
    logic       d_ld_n, d_ld_sum, d_clr_sum, d_n_sel, d_a_sel, d_b_sel, d_alu_sub, d_busy, d_done;

    always_comb begin
        state_nxt = ST_IDLE;
        case (state_r)
            ST_IDLE: state_nxt = start  ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_nxt = ST_TEST;
            ST_TEST: state_nxt = n_zero ? ST_DONE : ST_ADD;
            ST_ADD:  state_nxt = ST_DEC;
            ST_DEC:  state_nxt = ST_TEST;
            ST_DONE: state_nxt = ack    ? ST_IDLE : ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    sum_seq_decode u_decode (
        .state   (state_nxt),
        .ld_n    (d_ld_n),
        .ld_sum  (d_ld_sum),
        .clr_sum (d_clr_sum),
        .n_sel   (d_n_sel),
        .a_sel   (d_a_sel),
        .b_sel   (d_b_sel),
        .alu_sub (d_alu_sub),
        .busy    (d_busy),
        .done    (d_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ld_n       <= 1'b0;
            ld_sum     <= 1'b0;
            clr_sum    <= 1'b0;
            n_sel      <= 1'b0;
            a_sel      <= 1'b0;
            b_sel      <= 1'b0;
            alu_sub    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            iter_count <= 8'd0;
        end else begin
            state_r    <= state_nxt;
            ld_n       <= d_ld_n;
            ld_sum     <= d_ld_sum;
            clr_sum    <= d_clr_sum;
            n_sel      <= d_n_sel;
            a_sel      <= d_a_sel;
            b_sel      <= d_b_sel;
            alu_sub    <= d_alu_sub;
            busy       <= d_busy;
            done       <= d_done;
            // Cleared leaving LOAD, bumped leaving each ADD; held elsewhere.
            if (state_r == ST_LOAD)
                iter_count <= 8'd0;
            else if (state_r == ST_ADD)
                iter_count <= iter_count + 8'd1;
        end
    end

    assign state = state_r;
endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Directed bench for sum_seq_ctrl with a behavioural model of the 8-bit sum datapath.
module tb_sum_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset, start, ack, n_zero;
    logic       ld_n, ld_sum, clr_sum, n_sel, a_sel, b_sel, alu_sub, busy, done;
    logic [7:0] iter_count;
    logic [2:0] state;

    logic [7:0] operand = 8'd0;
    logic [7:0] dp_n = 8'd0;
    logic [7:0] dp_sum = 8'd0;
    logic [7:0] alu_a, alu_b, alu_r;
    logic [8:0] ctrl_vec;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sum_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .ack(ack), .n_zero(n_zero),
        .ld_n(ld_n), .ld_sum(ld_sum), .clr_sum(clr_sum), .n_sel(n_sel),
        .a_sel(a_sel), .b_sel(b_sel), .alu_sub(alu_sub), .busy(busy),
        .done(done), .iter_count(iter_count), .state(state)
    );

    // Datapath model: registers, muxes and add/sub ALU
    always_comb begin
        alu_a = a_sel ? dp_sum : dp_n;
        alu_b = b_sel ? dp_n : 8'd1;
        alu_r = alu_sub ? alu_a - alu_b : alu_a + alu_b;
    end
    assign n_zero   = (dp_n == 8'd0);
    assign ctrl_vec = {ld_n, ld_sum, clr_sum, n_sel, a_sel, b_sel, alu_sub, busy, done};

    always @(posedge clk) begin
        if (clr_sum)     dp_sum <= 8'd0;
        else if (ld_sum) dp_sum <= alu_r;
        if (ld_n)        dp_n <= n_sel ? operand : alu_r;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // {ld_n, ld_sum, clr_sum, n_sel, a_sel, b_sel, alu_sub, busy, done}
    function automatic logic [8:0] exp_vec(input int st);
        case (st)
            1:       return 9'b1_0_1_1_0_0_0_1_0;
            2:       return 9'b0_0_0_0_0_0_0_1_0;
            3:       return 9'b0_1_0_0_1_1_0_1_0;
            4:       return 9'b1_0_0_0_0_0_1_1_0;
            5:       return 9'b0_0_0_0_0_0_0_0_1;
            default: return 9'b0;
        endcase
    endfunction

    // state expected e edges after start was sampled
    function automatic int exp_state(input int e, input int n);
        if (e == 0)         return 1;
        if (e >= 3 * n + 2) return 5;
        case ((e - 1) % 3)
            0:       return 2;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int op, input int exp_sum, input bit chk_vecs, input bit hold);
        int e;
        int st;
        @(negedge clk);
        operand = op[7:0];
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        e = 0;
        while (!done && e < 1000) begin
            if (chk_vecs) begin
                st = exp_state(e, op);
                chk($sformatf("vec_n%0d_e%0d", op, e), {ctrl_vec, state}, {exp_vec(st), st[2:0]});
            end
            @(negedge clk);
            e++;
        end
        chk($sformatf("latency_n%0d", op), e, 3 * op + 2);
        chk($sformatf("iter_n%0d", op), iter_count, op);
        chk($sformatf("sum_n%0d", op), dp_sum, exp_sum);
        chk($sformatf("done_vec_n%0d", op), {ctrl_vec, state}, {exp_vec(5), 3'd5});
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_idle", state, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_ctrl", ctrl_vec, 0);
        chk("rst_iter", iter_count, 0);
        reset = 1'b0;

        run(5, 15, 1'b1, 1'b0);
        do_ack();
        run(0, 0, 1'b1, 1'b0);
        do_ack();
        run(23, 20, 1'b0, 1'b0);
        do_ack();
        run(255, 128, 1'b0, 1'b0);
        chk("iter_hold_done", iter_count, 255);
        do_ack();
        chk("iter_hold_idle", iter_count, 255);

        // reset mid-run while in DEC
        @(negedge clk);
        operand = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_dec", state, 4);
        reset = 1'b1;
        start = 1'b1;
        ack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        ack = 1'b0;
        chk("midrst_state", state, 0);
        chk("midrst_ctrl", ctrl_vec, 0);
        chk("midrst_iter", iter_count, 0);

        // start held through the run, ack withheld in DONE
        run(2, 3, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("hold_done_%0d", i), {done, state}, {1'b1, 3'd5});
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_start_idle", {done, state}, {1'b0, 3'd0});
        @(negedge clk);
        chk("restart_load", state, 1);
        start = 1'b0;
        do_reset();

        // illegal code recovers to IDLE; ack in IDLE is ignored
        @(negedge clk);
        force dut.state_r = 3'd6;
        #1;
        chk("forced_state", state, 6);
        release dut.state_r;
        @(negedge clk);
        chk("illegal_to_idle", state, 0);
        chk("illegal_ctrl", ctrl_vec, 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_in_idle", {ctrl_vec, state}, 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sum_seq_ctrl.md
# sum_seq_ctrl

Sequencing controller for the 8-bit dedicated sum datapath, which is built from the 8-bit load registers, the 2-to-1 muxes and the add/subtract ALU. On a start request it drives the datapath's mux selects, register loads and ALU add/subtract control to compute SUM = N + (N-1) + … + 1, modulo 256. It reads one status flag back from the datapath and reports completion through a start/done/ack handshake. It sits directly upstream of the datapath control pins and is the only writer of them.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request a computation; sampled only in IDLE
- ack  in  1  consumer has taken the result; sampled only in DONE
- n_zero  in  1  datapath status: N register == 0
- ld_n  out  1  load enable, N register
- ld_sum  out  1  load enable, SUM register
- clr_sum  out  1  synchronous clear, SUM register
- n_sel  out  1  N-input mux: 1 = external operand, 0 = ALU result
- a_sel  out  1  ALU A mux: 1 = SUM, 0 = N
- b_sel  out  1  ALU B mux: 1 = N, 0 = constant 1
- alu_sub  out  1  ALU: 1 = A-B, 0 = A+B
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  result valid in SUM register
- iter_count  out  8  number of ADD states executed in the current or last run
- state  out  3  current state encoding, for debug

## Operation
- Moore FSM. All outputs are decoded from the state register only.
- Outputs not listed for a state are 0.
- Operation to state mapping:
  - IDLE: all control outputs are 0.
  - LOAD: N is captured from the external operand.
  - TEST: no register loads; the branch is taken on n_zero.
  - ADD: SUM <= SUM + N.
  - DEC: N <= N - 1.
- States and transitions:
  - IDLE (0): start=1 -> LOAD, else stay.
  - LOAD (1): ld_n=1, n_sel=1, clr_sum=1, busy=1. iter_count is cleared to 0 on this edge. -> TEST.
  - TEST (2): busy=1. n_zero=1 -> DONE, else -> ADD.
  - ADD (3): ld_sum=1, a_sel=1, b_sel=1, alu_sub=0, busy=1. iter_count increments on the exit edge. -> DEC.
  - DEC (4): ld_n=1, n_sel=0, a_sel=0, b_sel=0, alu_sub=1, busy=1. -> TEST.
  - DONE (5): done=1. ack=1 -> IDLE, else stay.
  - Codes 6 and 7 are illegal -> IDLE on the next edge, with outputs as in IDLE.
- iter_count:
  - 8-bit, wraps 255 -> 0. With N at most 255 it never wraps.
  - Holds its value in IDLE and DONE until the next LOAD.
- start in any state other than IDLE is ignored, not queued.
- ack outside DONE is ignored.
- start and ack both high in DONE: ack wins -> IDLE. start is not sampled until the following IDLE cycle.
- Reset asserted in any state, including mid-run: next edge -> IDLE, all outputs 0, iter_count = 0. Reset overrides start and ack.
- The arithmetic itself lives in the datapath. This block guarantees only select and load correctness, so SUM wraps modulo 256.

## Timing
- Reset values: state=IDLE (0), iter_count=0, all other outputs 0.
- With start sampled high at edge k: LOAD during k..k+1, TEST after k+1.
- done rises after edge k + 3N + 2 and stays high until the edge at which ack is sampled high.
- Total busy cycles = 3N + 2.
- n_zero is read in TEST only. It must reflect N as registered at the preceding LOAD or DEC edge; no combinational path is required within the same cycle.
- Every control output is glitch-free, being a registered state decode. There is no combinational path from any input to any output.

## Structure
- Shared package sum_seq_pkg:
  - 3-bit state encoding constants ST_IDLE … ST_DONE.
  - Mux select constants: N_SEL_EXT/N_SEL_ALU, A_SEL_SUM/A_SEL_N, B_SEL_N/B_SEL_ONE.
  - ALU_ADD/ALU_SUB.
- One natural sub-module: sum_seq_decode, a purely combinational state-to-control-vector decode. It is reused by the datapath bench as a reference model.
- The top level holds the state register, next-state logic and iter_count.

## Test plan
- Reset during DEC with N=4 -> next cycle state=0, all controls 0, iter_count=0, done=0.
- start with operand 0 -> LOAD, TEST, DONE; done after 2 edges; iter_count=0; SUM=0 in the integration model.
- start with operand 5 -> done after 17 edges; iter_count=5; SUM=15. Check the ADD/DEC control vectors in every cycle.
- start with operand 23 -> iter_count=23, SUM=20 (276 mod 256). start=255 -> iter_count=255, SUM=128.
- Hold start high through the run and ack low for 10 cycles in DONE -> no restart; done held 10 cycles. Then ack plus start together -> IDLE, then LOAD one cycle later.
- Force state to 6 via a bench override -> IDLE on the next edge; ack pulse in IDLE has no effect.
